// File: rtl/relogio_pkg.sv
// Shared types, field limits and arithmetic helpers for the relogio timekeeping core.
package relogio_pkg;

    typedef enum logic [2:0] {
        MODE_RUN    = 3'd0,
        MODE_SET_H  = 3'd1,
        MODE_SET_M  = 3'd2,
        MODE_SET_S  = 3'd3,
        MODE_SET_AH = 3'd4,
        MODE_SET_AM = 3'd5
    } mode_e;

    localparam logic [5:0] MAX_SEC  = 6'd59;
    localparam logic [5:0] MAX_MIN  = 6'd59;
    localparam logic [5:0] MAX_HOUR = 6'd23;
    localparam logic [5:0] NOON     = 6'd12;

    function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
        return (val >= max) ? 6'd0 : val + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] val, input logic [5:0] max);
        return (val == 6'd0) ? max : val - 6'd1;
    endfunction

    function automatic logic [5:0] to_12h(input logic [5:0] hour);
        if (hour == 6'd0)
            return NOON;
        else if (hour > NOON)
            return hour - NOON;
        else
            return hour;
    endfunction

endpackage

// File: rtl/relogio_core_param_prescaler.sv
// 1 Hz tick and half-second blink generator; while held the main count sits at 0
// and a separate half-period counter keeps the blink running.
module relogio_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk_100MHz,
    input  logic rstn,
    input  logic hold,
    output logic tick,
    output logic blink
);
    localparam int CNT_W = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLK_HZ / 2 - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic             blink_q, blink_d;

    always_comb begin
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        blink_d = blink_q;
        if (hold) begin
            cnt_d = '0;
            if (hcnt_q == HALF) begin
                hcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                hcnt_d = hcnt_q + ONE;
            end
        end else begin
            hcnt_d = '0;
            cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + ONE;
            if (cnt_q == HALF || cnt_q == LAST)
                blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            hcnt_q  <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            blink_q <= blink_d;
        end
    end

    assign tick  = ~hold & (cnt_q == LAST);
    assign blink = blink_q;

endmodule

// File: rtl/relogio_core_param.sv
// hh:mm:ss timekeeping core with adjust-mode FSM, 12h/24h display and blink.
// Define RELOGIO_ALARM_EN to build the alarm registers, SET_AH/SET_AM and alarm_ring.
module relogio_core_param
    import relogio_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int RING_SECS = 30
) (
    input  logic       clk_100MHz,
    input  logic       rstn,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       fmt_12h,
    input  logic       alarm_on,
    output logic [5:0] segundos,
    output logic [5:0] minutos,
    output logic [5:0] horas,
    output logic       pm,
    output logic [2:0] modo_ajuste,
    output logic       blink,
    output logic       alarm_ring
);
`ifdef RELOGIO_ALARM_EN
    localparam mode_e LAST_MODE = MODE_SET_AM;
    localparam int    RC_W      = $clog2(RING_SECS + 1);
    localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECS - 1);
`else
    localparam mode_e LAST_MODE = MODE_SET_S;
`endif

    mode_e      mode_q, mode_d;
    logic [5:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
    logic       tick, blink_raw, hold, consumed;
    logic [5:0] min_show, hour_show;
    logic [5:0] seg_out_q, min_out_q, hour_out_q;
    logic [2:0] mode_out_q;
    logic       pm_out_q, blink_out_q;

    assign hold = (mode_q != MODE_RUN);

    relogio_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
        .clk_100MHz (clk_100MHz),
        .rstn       (rstn),
        .hold       (hold),
        .tick       (tick),
        .blink      (blink_raw)
    );

`ifdef RELOGIO_ALARM_EN
    logic [5:0]      al_h_q, al_h_d, al_m_q, al_m_d;
    logic            ring_q, ring_d, ring_out_q;
    logic [RC_W-1:0] ring_cnt_q, ring_cnt_d;
`endif

    always_comb begin
        mode_d   = mode_q;
        sec_d    = sec_q;
        min_d    = min_q;
        hour_d   = hour_q;
        consumed = 1'b0;
`ifdef RELOGIO_ALARM_EN
        al_h_d     = al_h_q;
        al_m_d     = al_m_q;
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        // Any pulse that arrives while ringing only silences the alarm.
        consumed   = ring_q & (btn_mode | btn_inc | btn_dec);
`endif
        if (tick) begin
            sec_d = wrap_inc(sec_q, MAX_SEC);
            if (sec_q == MAX_SEC) begin
                min_d = wrap_inc(min_q, MAX_MIN);
                if (min_q == MAX_MIN)
                    hour_d = wrap_inc(hour_q, MAX_HOUR);
            end
        end
        if (!consumed) begin
            if (btn_mode) begin
                mode_d = (mode_q == LAST_MODE) ? MODE_RUN : mode_e'(mode_q + 3'd1);
            end else if (btn_inc ^ btn_dec) begin
                case (mode_q)
                    MODE_SET_H:  hour_d = btn_inc ? wrap_inc(hour_q, MAX_HOUR) : wrap_dec(hour_q, MAX_HOUR);
                    MODE_SET_M:  min_d  = btn_inc ? wrap_inc(min_q, MAX_MIN)   : wrap_dec(min_q, MAX_MIN);
                    MODE_SET_S:  sec_d  = btn_inc ? wrap_inc(sec_q, MAX_SEC)   : wrap_dec(sec_q, MAX_SEC);
`ifdef RELOGIO_ALARM_EN
                    MODE_SET_AH: al_h_d = btn_inc ? wrap_inc(al_h_q, MAX_HOUR) : wrap_dec(al_h_q, MAX_HOUR);
                    MODE_SET_AM: al_m_d = btn_inc ? wrap_inc(al_m_q, MAX_MIN)  : wrap_dec(al_m_q, MAX_MIN);
`endif
                    default: ;
                endcase
            end
        end
`ifdef RELOGIO_ALARM_EN
        if (ring_q) begin
            if (!alarm_on || consumed) begin
                ring_d = 1'b0;
            end else if (tick) begin
                if (ring_cnt_q == RING_LAST)
                    ring_d = 1'b0;
                else
                    ring_cnt_d = ring_cnt_q + RC_W'(1);
            end
        end else if (tick && alarm_on && sec_d == 6'd0 && min_d == al_m_q && hour_d == al_h_q) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end
`endif
    end

`ifdef RELOGIO_ALARM_EN
    assign min_show  = (mode_q == MODE_SET_AM) ? al_m_q : min_q;
    assign hour_show = (mode_q == MODE_SET_AH) ? al_h_q : hour_q;

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            al_h_q     <= '0;
            al_m_q     <= '0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
            ring_out_q <= 1'b0;
        end else begin
            al_h_q     <= al_h_d;
            al_m_q     <= al_m_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
            ring_out_q <= ring_q;
        end
    end

    assign alarm_ring = ring_out_q;
`else
    logic unused_cfg;
    assign unused_cfg = alarm_on & (RING_SECS > 0);
    assign min_show   = min_q;
    assign hour_show  = hour_q;
    assign alarm_ring = 1'b0;
`endif

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            mode_q      <= MODE_RUN;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            seg_out_q   <= '0;
            min_out_q   <= '0;
            hour_out_q  <= '0;
            pm_out_q    <= 1'b0;
            mode_out_q  <= '0;
            blink_out_q <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            seg_out_q   <= sec_q;
            min_out_q   <= min_show;
            hour_out_q  <= fmt_12h ? to_12h(hour_show) : hour_show;
            pm_out_q    <= (hour_q >= NOON);
            mode_out_q  <= mode_q;
            blink_out_q <= hold & blink_raw;
        end
    end

    assign segundos    = seg_out_q;
    assign minutos     = min_out_q;
    assign horas       = hour_out_q;
    assign pm          = pm_out_q;
    assign modo_ajuste = mode_out_q;
    assign blink       = blink_out_q;

endmodule

// File: tb/tb_relogio_core_param.sv
// Self-checking bench for relogio_core_param: a time-of-day reference model in plain
// arithmetic is stepped every clock and compared with all outputs, plus directed checks.
`timescale 1ns/1ps
module tb_relogio_core_param;
    localparam int CLK_HZ    = 10;
    localparam int HALF      = CLK_HZ / 2;
    localparam int RING_SECS = 3;
    localparam int DAY       = 86400;
`ifdef RELOGIO_ALARM_EN
    localparam int N_MODES = 6;
`else
    localparam int N_MODES = 4;
`endif

    logic       clk_100MHz = 1'b0;
    logic       rstn = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic       fmt_12h = 1'b0, alarm_on = 1'b0;
    logic [5:0] segundos, minutos, horas;
    logic       pm, blink, alarm_ring;
    logic [2:0] modo_ajuste;

    int n_checks = 0;
    int n_errors = 0;
    int m_mode, m_t, m_run, m_hold, m_blink, m_ah, m_am, m_ring, m_ring_cnt;
    int e_seg, e_min, e_hour, e_pm, e_modo, e_blink, e_ring;

    always #5 clk_100MHz = ~clk_100MHz;

    relogio_core_param #(.CLK_HZ(CLK_HZ), .RING_SECS(RING_SECS)) dut (
        .clk_100MHz  (clk_100MHz),
        .rstn        (rstn),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .fmt_12h     (fmt_12h),
        .alarm_on    (alarm_on),
        .segundos    (segundos),
        .minutos     (minutos),
        .horas       (horas),
        .pm          (pm),
        .modo_ajuste (modo_ajuste),
        .blink       (blink),
        .alarm_ring  (alarm_ring)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_t = 0; m_run = 0; m_hold = 0; m_blink = 0;
        m_ah = 0; m_am = 0; m_ring = 0; m_ring_cnt = 0;
        e_seg = 0; e_min = 0; e_hour = 0; e_pm = 0; e_modo = 0; e_blink = 0; e_ring = 0;
    endfunction

    // One clock edge of the reference: outputs show the state held before the edge.
    function automatic void model_step();
        int  hsel, h, m, s, d;
        bit  tk, consumed;
        hsel   = (m_mode == 4) ? m_ah : m_t / 3600;
        e_seg  = m_t % 60;
        e_min  = (m_mode == 5) ? m_am : (m_t / 60) % 60;
        e_hour = fmt_12h ? ((hsel % 12 == 0) ? 12 : hsel % 12) : hsel;
        e_pm   = (m_t / 3600 >= 12) ? 1 : 0;
        e_modo = m_mode;
        e_blink = (m_mode != 0) ? m_blink : 0;
        e_ring = m_ring;
        if (m_mode == 0) begin
            tk = (m_run % CLK_HZ == CLK_HZ - 1);
            if (m_run % HALF == HALF - 1) m_blink ^= 1;
            m_run++;
            m_hold = 0;
        end else begin
            tk = 0;
            if (m_hold % HALF == HALF - 1) m_blink ^= 1;
            m_hold++;
            m_run = 0;
        end
        consumed = (m_ring != 0) && (btn_mode || btn_inc || btn_dec);
        if (tk) m_t = (m_t + 1) % DAY;
`ifdef RELOGIO_ALARM_EN
        if (m_ring != 0) begin
            if (!alarm_on || consumed) m_ring = 0;
            else if (tk) begin
                m_ring_cnt++;
                if (m_ring_cnt == RING_SECS) m_ring = 0;
            end
        end else if (tk && alarm_on && m_t == m_ah * 3600 + m_am * 60) begin
            m_ring = 1;
            m_ring_cnt = 0;
        end
`endif
        if (!consumed) begin
            if (btn_mode) begin
                m_mode = (m_mode + 1) % N_MODES;
            end else if (btn_inc != btn_dec) begin
                d = btn_inc ? 1 : -1;
                h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
                case (m_mode)
                    1: h = (h + d + 24) % 24;
                    2: m = (m + d + 60) % 60;
                    3: s = (s + d + 60) % 60;
                    4: m_ah = (m_ah + d + 24) % 24;
                    5: m_am = (m_am + d + 60) % 60;
                    default: ;
                endcase
                m_t = h * 3600 + m * 60 + s;
            end
        end
    endfunction

    function automatic int field_of(input int mode);
        case (mode)
            1: return m_t / 3600;
            2: return (m_t / 60) % 60;
            3: return m_t % 60;
            4: return m_ah;
            5: return m_am;
            default: return 0;
        endcase
    endfunction

    task automatic check_outputs();
        check_eq("segundos", segundos, e_seg);
        check_eq("minutos", minutos, e_min);
        check_eq("horas", horas, e_hour);
        check_eq("pm", pm, e_pm);
        check_eq("modo_ajuste", modo_ajuste, e_modo);
        check_eq("blink", blink, e_blink);
        check_eq("alarm_ring", alarm_ring, e_ring);
    endtask

    task automatic do_cycle(input logic m, input logic i, input logic d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(posedge clk_100MHz);
        model_step();
        @(negedge clk_100MHz);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        check_outputs();
    endtask

    task automatic goto_mode(input int target);
        for (int k = 0; k < 12 && m_mode != target; k++) do_cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_field(input int mode, input int target);
        goto_mode(mode);
        for (int k = 0; k < 64 && field_of(mode) != target; k++) do_cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int toggles, n;
        logic prev;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk_100MHz);
        rstn = 1'b1;
        $display("reset released");

        repeat (25) do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("run_two_ticks_sec", segundos, 2);

        goto_mode(1);
        do_cycle(1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("set_h_dec_wrap", horas, 23);
        goto_mode(2);
        do_cycle(1'b0, 1'b0, 1'b1);
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("set_m_inc_wrap", minutos, 0);
        check_eq("set_m_hour_kept", horas, 23);
        do_cycle(1'b0, 1'b0, 1'b1);
        set_field(3, 58);
        do_cycle(1'b0, 1'b1, 1'b1);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("inc_dec_same_cycle", segundos, 58);
        $display("time set to 23:59:58 in SET_S");

        prev = blink;
        toggles = 0;
        for (int k = 0; k < 50; k++) begin
            do_cycle(1'b0, 1'b0, 1'b0);
            if (blink != prev) toggles++;
            prev = blink;
        end
        check_eq("set_blink_toggles", toggles, 10);
        check_eq("set_sec_frozen", segundos, 58);

        do_cycle(1'b1, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("mode_beats_inc", modo_ajuste, (3 + 1) % N_MODES);
        check_eq("mode_beats_inc_sec", segundos, 58);
        goto_mode(0);
        for (int k = 0; k < 40 && m_t != 0; k++) do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("midnight_h", horas, 0);
        check_eq("midnight_m", minutos, 0);
        check_eq("midnight_s", segundos, 0);
        check_eq("midnight_pm", pm, 0);

        fmt_12h = 1'b1;
        set_field(1, 0);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("h12_from0", horas, 12);
        check_eq("pm_from0", pm, 0);
        set_field(1, 12);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("h12_from12", horas, 12);
        check_eq("pm_from12", pm, 1);
        set_field(1, 13);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("h12_from13", horas, 1);
        check_eq("pm_from13", pm, 1);
        fmt_12h = 1'b0;
        goto_mode(0);
        $display("12h mapping checked");

`ifdef RELOGIO_ALARM_EN
        alarm_on = 1'b1;
        set_field(1, 0);
        set_field(2, 0);
        set_field(3, 59);
        set_field(4, 0);
        set_field(5, 1);
        goto_mode(0);
        for (int k = 0; k < 40 && m_ring == 0; k++) do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("ring_start", alarm_ring, 1);
        check_eq("ring_start_min", minutos, 1);
        n = 1;
        for (int k = 0; k < 100; k++) begin
            do_cycle(1'b0, 1'b0, 1'b0);
            if (alarm_ring) n++;
            else break;
        end
        check_eq("ring_length", n, RING_SECS * CLK_HZ);
        set_field(2, 0);
        set_field(3, 59);
        goto_mode(0);
        for (int k = 0; k < 40 && m_ring == 0; k++) do_cycle(1'b0, 1'b0, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("ring_again", alarm_ring, 1);
        do_cycle(1'b0, 1'b1, 1'b0);
        do_cycle(1'b0, 1'b0, 1'b0);
        check_eq("ring_cancel", alarm_ring, 0);
        check_eq("ring_cancel_min", minutos, 1);
        check_eq("ring_cancel_mode", modo_ajuste, 0);
        $display("alarm ring checked");
`endif

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(49) == 0) fmt_12h = ~fmt_12h;
            if ($urandom_range(99) == 0) alarm_on = ~alarm_on;
            do_cycle($urandom_range(29) == 0, $urandom_range(5) == 0, $urandom_range(5) == 0);
        end
        fmt_12h = 1'b0;
        $display("random phase done");

        set_field(1, 12);
        set_field(2, 34);
        set_field(3, 56);
        goto_mode(2);
        #2 rstn = 1'b0;
        #1;
        check_eq("arst_seg", segundos, 0);
        check_eq("arst_min", minutos, 0);
        check_eq("arst_hour", horas, 0);
        check_eq("arst_pm", pm, 0);
        check_eq("arst_mode", modo_ajuste, 0);
        check_eq("arst_blink", blink, 0);
        check_eq("arst_ring", alarm_ring, 0);
        model_reset();
        @(negedge clk_100MHz);
        check_outputs();
        rstn = 1'b1;
        repeat (30) do_cycle(1'b0, 1'b0, 1'b0);
        $display("mid-operation reset checked");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
